daio_transmitter: RTL and testbench

DAIO_TRANSMITTER -- requirements
Module: daio_transmitter

---
 rtl/daio_pkg.sv | 47 ++++
 rtl/daio_transmitter_if.sv | 26 ++
 rtl/daio_biphase_enc.sv | 63 ++++++
 rtl/daio_transmitter.sv | 152 +++++++++++++++
 tb/tb_daio_transmitter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/daio_pkg.sv
// Shared types and constants for the DAIO biphase-mark transmitter.
// Framing geometry, preamble patterns and the per-slot bit selection live here.
package daio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SUB_A,
        ST_SUB_B
    } daio_state_e;

    localparam int AUDIO_W            = 20;
    localparam int FRAMES_PER_BLOCK   = 192;
    localparam int HALF_CELLS_PER_SUB = 64;
    localparam int PREAMBLE_HC        = 8;

    localparam int SLOT_AUDIO_LSB = 8;
    localparam int SLOT_AUDIO_MSB = 27;
    localparam int SLOT_PARITY    = 31;

    // Leftmost bit is the first half-cell on the line.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    typedef struct packed {
        logic [AUDIO_W-1:0] a;
        logic [AUDIO_W-1:0] b;
    } pair_t;

    // Data bit carried by a non-preamble slot; aux, V, U and C are always zero.
    function automatic logic slot_bit(input logic [4:0] slot,
                                      input logic [AUDIO_W-1:0] word,
                                      input logic par_en);
        logic [4:0] idx;
        logic       b;
        idx = slot - 5'(SLOT_AUDIO_LSB);
        b   = 1'b0;
        if (slot >= 5'(SLOT_AUDIO_LSB) && slot <= 5'(SLOT_AUDIO_MSB)) begin
            b = word[idx];
        end else if (slot == 5'(SLOT_PARITY)) begin
            b = par_en & (^word);
        end
        return b;
    endfunction

endpackage

// File: rtl/daio_transmitter_if.sv
// Audio-pair handshake, control/status and line-output bundle of the DAIO transmitter.
// The master side offers pairs and control; the slave side is the transmitter.
interface daio_transmitter_if;
    import daio_pkg::*;

    logic [3:0]         tx_control;
    logic [AUDIO_W-1:0] data_A;
    logic [AUDIO_W-1:0] data_B;
    logic               data_valid;
    logic               data_ready;
    logic               biphase_out;
    logic               preamble_out;
    logic [1:0]         frame_ofs;
    logic [3:0]         tx_status;

    modport master (
        output tx_control, data_A, data_B, data_valid,
        input  data_ready, biphase_out, preamble_out, frame_ofs, tx_status
    );

    modport slave (
        input  tx_control, data_A, data_B, data_valid,
        output data_ready, biphase_out, preamble_out, frame_ofs, tx_status
    );

endinterface

// File: rtl/daio_biphase_enc.sv
// Biphase-mark line encoder: one registered half-cell per clock, preamble override.
// Latency 1 clock from half-cell index to line output; no backpressure (free-running).
module daio_biphase_enc
    import daio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       run,
    input  logic [5:0] hc,
    input  logic [7:0] pre_pat,
    input  logic       sbit,
    output logic       biphase_out,
    output logic       preamble_out
);

    logic       biphase_q, biphase_d;
    logic       pre_q, pre_d;
    logic       pol_q, pol_d;
    logic       pol;
    logic [2:0] pre_idx;

    always_comb begin
        biphase_d = biphase_q;
        pre_d     = 1'b0;
        pol_d     = pol_q;
        // Preamble polarity follows the line level just before half-cell 0.
        pol       = (hc == 6'd0) ? biphase_q : pol_q;
        pre_idx   = 3'd7 - hc[2:0];
        if (clr) begin
            biphase_d = 1'b0;
            pol_d     = 1'b0;
        end else if (run) begin
            if (hc == 6'd0) begin
                pol_d = biphase_q;
            end
            if (hc < 6'(PREAMBLE_HC)) begin
                biphase_d = pre_pat[pre_idx] ^ pol;
                pre_d     = 1'b1;
            end else if (!hc[0]) begin
                biphase_d = ~biphase_q;
            end else begin
                biphase_d = biphase_q ^ sbit;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            biphase_q <= 1'b0;
            pre_q     <= 1'b0;
            pol_q     <= 1'b0;
        end else begin
            biphase_q <= biphase_d;
            pre_q     <= pre_d;
            pol_q     <= pol_d;
        end
    end

    assign biphase_out  = biphase_q;
    assign preamble_out = pre_q;

endmodule

// File: rtl/daio_transmitter.sv
// DAIO transmitter: buffers 20-bit A/B pairs and sends 192-frame blocks as biphase-mark.
// Line output lags the half-cell counter by 1 clock; data_ready low while one pair is pending.
module daio_transmitter
    import daio_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    daio_transmitter_if.slave  bus
);

    daio_state_e state_q, state_d;
    logic [5:0]  hc_q, hc_d;
    logic [7:0]  frame_q, frame_d;
    pair_t       pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    pair_t       work_q, work_d;
    logic        stop_q, stop_d;
    logic        rdy_q, rdy_d;
    logic [1:0]  ofs_q, ofs_d;
    logic [3:0]  status_q, status_d;

    logic               en, par_en, in_sub, sub_d, last_hc, xfer, accept;
    logic               underrun_d;
    logic [AUDIO_W-1:0] word;
    logic [7:0]         pre_pat;
    logic               sbit;

    always_comb begin
        en      = bus.tx_control[2];
        par_en  = bus.tx_control[3];
        in_sub  = (state_q == ST_SUB_A) || (state_q == ST_SUB_B);
        last_hc = (hc_q == 6'(HALF_CELLS_PER_SUB - 1));
        xfer    = (state_q == ST_SUB_A) && (hc_q == 6'd0);
        accept  = bus.data_valid && rdy_q;

        state_d     = state_q;
        hc_d        = hc_q;
        frame_d     = frame_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        work_d      = work_q;
        stop_d      = stop_q;
        underrun_d  = status_q[0];

        case (state_q)
            ST_IDLE: begin
                hc_d    = 6'd0;
                frame_d = 8'd0;
                stop_d  = 1'b0;
                if (en) begin
                    state_d    = ST_ARM;
                    underrun_d = 1'b0;
                end
            end
            ST_ARM: begin
                hc_d    = 6'd0;
                frame_d = 8'd0;
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (pend_full_q) begin
                    state_d = ST_SUB_A;
                end
            end
            ST_SUB_A: begin
                hc_d = hc_q + 6'd1;
                if (!en) stop_d = 1'b1;
                if (last_hc) state_d = ST_SUB_B;
            end
            ST_SUB_B: begin
                hc_d = hc_q + 6'd1;
                if (!en) stop_d = 1'b1;
                if (last_hc) begin
                    // A disable anywhere in the frame takes effect only at its end.
                    if (stop_q || !en) begin
                        state_d = ST_IDLE;
                        frame_d = 8'd0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_SUB_A;
                        frame_d = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Transfer is applied before acceptance so a same-cycle new pair survives.
        if (xfer) begin
            work_d      = pend_full_q ? pend_q : '0;
            pend_full_d = 1'b0;
            if (!pend_full_q) underrun_d = 1'b1;
        end
        if (accept) begin
            pend_d      = '{a: bus.data_A, b: bus.data_B};
            pend_full_d = 1'b1;
        end

        rdy_d    = !pend_full_d;
        sub_d    = (state_d == ST_SUB_A) || (state_d == ST_SUB_B);
        ofs_d    = frame_d[1:0];
        status_d = {1'b0, sub_d && (frame_d == 8'd0), sub_d, underrun_d};
    end

    always_comb begin
        word    = (state_q == ST_SUB_B) ? work_q.b : work_q.a;
        pre_pat = (state_q == ST_SUB_B) ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
        sbit    = slot_bit(hc_q[5:1], word, par_en);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hc_q        <= 6'd0;
            frame_q     <= 8'd0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            work_q      <= '0;
            stop_q      <= 1'b0;
            rdy_q       <= 1'b1;
            ofs_q       <= 2'd0;
            status_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            frame_q     <= frame_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            work_q      <= work_d;
            stop_q      <= stop_d;
            rdy_q       <= rdy_d;
            ofs_q       <= ofs_d;
            status_q    <= status_d;
        end
    end

    daio_biphase_enc u_enc (
        .clock        (clock),
        .reset        (reset),
        .clr          (!in_sub),
        .run          (in_sub),
        .hc           (hc_q),
        .pre_pat      (pre_pat),
        .sbit         (sbit),
        .biphase_out  (bus.biphase_out),
        .preamble_out (bus.preamble_out)
    );

    assign bus.data_ready = rdy_q;
    assign bus.frame_ofs  = ofs_q;
    assign bus.tx_status  = status_q;

endmodule

// File: tb/tb_daio_transmitter.sv
// Directed bench for daio_transmitter: 194 frames against a line model, then disable and reset.
module tb_daio_transmitter;

    localparam logic [7:0] TB_B = 8'b11101000;
    localparam logic [7:0] TB_M = 8'b11100010;
    localparam logic [7:0] TB_W = 8'b11100100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    daio_transmitter_if bus ();

    daio_transmitter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] first8(input logic [63:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    // Reference biphase-mark line for one subframe, index 0 = first half-cell.
    task automatic gen_sub(input logic [7:0] pre, input logic [19:0] w, input bit par,
                           input bit lvl_in, output logic [63:0] v, output bit lvl_out);
        bit l;
        bit b;
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = pre[7-i] ^ lvl_in;
        l = v[7];
        for (int s = 4; s < 32; s++) begin
            if (s >= 8 && s <= 27) b = w[s-8];
            else if (s == 31)      b = par & (^w);
            else                   b = 1'b0;
            l = ~l;
            v[2*s] = l;
            l = l ^ b;
            v[2*s+1] = l;
        end
        lvl_out = l;
    endtask

    task automatic get_sub(input bit offer, input logic [19:0] a, input logic [19:0] b,
                           input int drop_k, output logic [63:0] line,
                           output logic [63:0] pv, output bit rdy_first);
        line = '0;
        pv   = '0;
        rdy_first = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            line[k] = bus.biphase_out;
            pv[k]   = bus.preamble_out;
            if (k == 0) rdy_first = bus.data_ready;
            if (offer && k == 0) begin
                bus.data_A = a;
                bus.data_B = b;
                bus.data_valid = 1'b1;
            end
            if (offer && k == 1) bus.data_valid = 1'b0;
            if (k == drop_k) bus.tx_control[2] = 1'b0;
        end
    endtask

    task automatic wait_active();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = bus.tx_status[1];
        end
        if (!seen) check_eq("wait_active_timeout", 64'(seen), 64'd1);
    endtask

    initial begin
        logic [63:0] la, lb, pa, pb, ea, eb;
        logic [19:0] cur_a, cur_b, nxt_a, nxt_b;
        bit          rdy, lvl, lvl_pre, par, offer;
        int          bf;

        bus.tx_control = 4'b0000;
        bus.data_A     = '0;
        bus.data_B     = '0;
        bus.data_valid = 1'b0;
        #12;
        check_eq("rst_biphase",  64'(bus.biphase_out),  64'd0);
        check_eq("rst_preamble", 64'(bus.preamble_out), 64'd0);
        check_eq("rst_ready",    64'(bus.data_ready),   64'd1);
        check_eq("rst_ofs",      64'(bus.frame_ofs),    64'd0);
        check_eq("rst_status",   64'(bus.tx_status),    64'd0);
        reset = 1'b0;
        tick();

        // First pair buffered while idle, then enable with parity on.
        bus.data_A = 20'h00001;
        bus.data_B = 20'h00000;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check_eq("ready_after_accept", 64'(bus.data_ready), 64'd0);
        bus.tx_control = 4'b1100;
        wait_active();
        check_eq("ready_at_entry", 64'(bus.data_ready), 64'd0);

        cur_a = 20'h00001;
        cur_b = 20'h00000;
        lvl   = 1'b0;
        for (int f = 0; f < 194; f++) begin
            bf    = f % 192;
            par   = (f != 3);
            bus.tx_control[3] = par;
            offer = (f >= 1 && f <= 192);
            if (f == 1 || f == 2) begin
                nxt_a = 20'hFFFFF;
                nxt_b = 20'h00007;
            end else begin
                nxt_a = 20'(f * 20'h01357) ^ 20'hA5C3E;
                nxt_b = 20'(f * 20'h00F0F + 3);
            end

            get_sub(offer, nxt_a, nxt_b, (f == 193) ? 10 : -1, la, pa, rdy);
            lvl_pre = lvl;
            gen_sub((bf == 0) ? TB_B : TB_M, cur_a, par, lvl, ea, lvl);
            check_eq($sformatf("subA_f%0d", f), la, ea);
            check_eq($sformatf("ofs_f%0d", f), 64'(bus.frame_ofs), 64'(bf % 4));
            check_eq($sformatf("status_f%0d", f), 64'(bus.tx_status),
                     64'({1'b0, bf == 0, 1'b1, f >= 1}));
            if (f == 0) begin
                check_eq("first_preamble", 64'(first8(la)), 64'(TB_B));
                check_eq("preamble_mask", pa, 64'h00000000000000FF);
                check_eq("ready_one_after_entry", 64'(rdy), 64'd1);
            end
            if (f == 192) check_eq("wrap_preamble_B", 64'(first8(la) ^ {8{lvl_pre}}), 64'(TB_B));

            get_sub(1'b0, 20'h0, 20'h0, -1, lb, pb, rdy);
            gen_sub(TB_W, cur_b, par, lvl, eb, lvl);
            check_eq($sformatf("subB_f%0d", f), lb, eb);
            if (f == 2) begin
                check_eq("par_on_A_slot31", 64'(la[62] ^ la[63]), 64'd0);
                check_eq("par_on_B_slot31", 64'(lb[62] ^ lb[63]), 64'd1);
            end
            if (f == 3) begin
                check_eq("par_off_A_slot31", 64'(la[62] ^ la[63]), 64'd0);
                check_eq("par_off_B_slot31", 64'(lb[62] ^ lb[63]), 64'd0);
            end
            cur_a = offer ? nxt_a : 20'h0;
            cur_b = offer ? nxt_b : 20'h0;
        end

        // Frame with the enable dropped has completed; line must settle to 0.
        check_eq("drop_inactive", 64'(bus.tx_status[1]), 64'd0);
        tick();
        check_eq("drop_biphase", 64'(bus.biphase_out), 64'd0);
        tick();
        tick();
        check_eq("idle_status", 64'(bus.tx_status), 64'd1);
        check_eq("idle_biphase", 64'(bus.biphase_out), 64'd0);

        // Re-arm clears the sticky underrun; then reset mid-SUB_B.
        bus.data_A = 20'h12345;
        bus.data_B = 20'h54321;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.tx_control = 4'b0100;
        wait_active();
        check_eq("rearm_status", 64'(bus.tx_status), 64'd6);
        get_sub(1'b0, 20'h0, 20'h0, -1, la, pa, rdy);
        for (int i = 0; i < 30; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_biphase",  64'(bus.biphase_out),  64'd0);
        check_eq("arst_preamble", 64'(bus.preamble_out), 64'd0);
        check_eq("arst_ready",    64'(bus.data_ready),   64'd1);
        check_eq("arst_ofs",      64'(bus.frame_ofs),    64'd0);
        check_eq("arst_status",   64'(bus.tx_status),    64'd0);
        #10;
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
